// File: rtl/rle_pkg.sv
// Shared definitions for the parametrised run-length encoder.
//   ew_of()           : effective word width 8*(mode+1), clamped to the sample width
//   make_count_word() : count word with the flag at bit ew-1 and zeros above ew
//   FLAG_BYTE_MAX     : largest count a count word can carry in byte mode
//   run_state_e       : run tracker state (idle / a value word already emitted)
// Functions work on MAX_DW-bit vectors; callers size-cast the result to DW.
package rle_pkg;

  localparam int MAX_DW        = 256;
  localparam int FLAG_BYTE_MAX = 127;

  typedef logic [MAX_DW-1:0] wide_t;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  function automatic int ew_of(input int mode, input int dw);
    int ew;
    ew = 8 * (mode + 1);
    if (ew > dw) ew = dw;
    return ew;
  endfunction

  // With repeat_mode set the reported count includes the first occurrence.
  function automatic wide_t make_count_word(input wide_t cnt, input int ew,
                                            input logic repeat_mode);
    wide_t w;
    w = cnt + wide_t'(repeat_mode);
    for (int i = 0; i < MAX_DW; i++) begin
      if (i == ew - 1)     w[i] = 1'b1;
      else if (i > ew - 1) w[i] = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/rle_encoder_param_outq.sv
// Output queue of the run-length encoder: circular buffer accepting up to two
// pushes per cycle and popping one word per cycle into a registered output.
//   clock, reset     : clock, asynchronous active-high reset
//   push0 / wdata0   : first word this cycle
//   push1 / wdata1   : second word this cycle (stored after wdata0)
//   stall            : holds the pop side (test hook)
//   rdata / rvalid   : registered queue head
//   empty            : no stored words
//   overflow         : sticky, set when a pushed word found no free slot
module rle_outq #(
  parameter int DW     = 32,
  parameter int QDEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push0,
  input  logic [DW-1:0] wdata0,
  input  logic          push1,
  input  logic [DW-1:0] wdata1,
  input  logic          stall,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          empty,
  output logic          overflow
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem [QDEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] space;
  logic [CNT_W-1:0] need1;
  logic             pop;
  logic             acc0;
  logic             acc1;
  logic             drop;

  assign empty = (count == '0);

  // The slot freed by this cycle's pop is reusable by this cycle's pushes.
  always_comb begin
    pop   = !empty && !stall;
    space = CNT_W'(QDEPTH) - count + CNT_W'(pop);
    acc0  = push0 && (space != '0);
    need1 = acc0 ? CNT_W'(2) : CNT_W'(1);
    acc1  = push1 && (space >= need1);
    drop  = (push0 && !acc0) || (push1 && !acc1);
  end

  always_ff @(posedge clock) begin
    if (acc0) mem[tail] <= wdata0;
    if (acc1) mem[tail + PTR_W'(acc0)] <= wdata1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rvalid <= pop;
      if (pop) begin
        rdata <= mem[head];
        head  <= head + 1'b1;
      end
      tail  <= tail + PTR_W'(acc0) + PTR_W'(acc1);
      count <= count + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rle_encoder_param.sv
// Parametrised run-length encoder between the sampler/trigger path and the
// sample memory. Emits value words (flag bit EW-1 clear) and count words
// (flag bit set, repeat count below it) through a small output queue.
//   clock, reset   : sample clock, asynchronous active-high reset
//   enable         : 1 = encode, 0 = bypass (masked samples passed through)
//   mode           : effective word width EW = 8*(mode+1), clamped to DW
//   repeat_mode    : count words include the first occurrence
//   data_mask      : per-channel enable, disabled bits forced to 0
//   flush          : single-cycle pulse closing the current run
//   dataIn/validIn : sample and strobe
//   test_stall     : holds the queue's pop side; tie low in normal use
//   dataOut/validOut : encoded word, at most one per cycle
//   flush_done     : single-cycle pulse once a flush has fully drained
//   overflow       : sticky queue overflow flag
// Handshake: a sample is consumed in every cycle validIn is high (no
// backpressure); dataOut is meaningful only in cycles where validOut is high.
module rle_encoder_param
  import rle_pkg::*;
#(
  parameter int DW     = 32,
  parameter int QDEPTH = 4,
  parameter int MODE_W = (DW / 8 > 1) ? $clog2(DW / 8) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode,
  input  logic              repeat_mode,
  input  logic [DW-1:0]     data_mask,
  input  logic              flush,
  input  logic [DW-1:0]     dataIn,
  input  logic              validIn,
  input  logic              test_stall,
  output logic [DW-1:0]     dataOut,
  output logic              validOut,
  output logic              flush_done,
  output logic              overflow
);

  int            ew;
  logic [DW-1:0] ew_mask;
  logic [DW-1:0] flag_mask;
  logic [DW-1:0] maxc;
  logic [DW-1:0] split;
  logic [DW-1:0] m_byp;
  logic [DW-1:0] m_val;

  run_state_e    state, state_n;
  logic [DW-1:0] last, last_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [DW-1:0] cnt_inc;
  logic [DW-1:0] cnt_src;
  logic [DW-1:0] fl_src;
  logic          a_byp, a_val, a_cnt, a_fl;

  logic          push0, push1;
  logic [DW-1:0] w0, w1;
  logic [DW-1:0] vword;
  logic [DW-1:0] cword_run;
  logic [DW-1:0] cword_fl;

  logic          q_empty;
  logic          flush_pending;

  // Width-dependent masks. With repeat_mode the internal split happens one
  // count earlier so the reported value still saturates at MAXC.
  always_comb begin
    ew = ew_of(int'(mode), DW);
    for (int i = 0; i < DW; i++) begin
      ew_mask[i]   = (i < ew);
      flag_mask[i] = (i == ew - 1);
      maxc[i]      = (i < ew - 1);
    end
    split = repeat_mode ? (maxc - DW'(1)) : maxc;
    m_byp = dataIn & data_mask & ew_mask;
    m_val = m_byp & ~flag_mask;
  end

  // Run tracker state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN_IDLE;
      last  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: the sample is handled first, then a coincident flush closes
  // whatever run the sample left open.
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    cnt_inc = cnt + DW'(1);
    cnt_src = '0;
    fl_src  = '0;
    a_byp   = 1'b0;
    a_val   = 1'b0;
    a_cnt   = 1'b0;
    a_fl    = 1'b0;
    if (validIn) begin
      if (!enable) begin
        a_byp   = 1'b1;
        state_n = RUN_IDLE;
        last_n  = '0;
        cnt_n   = '0;
      end else if (state == RUN_IDLE) begin
        a_val   = 1'b1;
        state_n = RUN_ACTIVE;
        last_n  = m_val;
        cnt_n   = '0;
      end else if (m_val == last) begin
        if (cnt_inc == split) begin
          // Saturated: report and keep the run going without a new value word.
          a_cnt   = 1'b1;
          cnt_src = cnt_inc;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end else begin
        if (cnt != '0) begin
          a_cnt   = 1'b1;
          cnt_src = cnt;
        end
        a_val  = 1'b1;
        last_n = m_val;
        cnt_n  = '0;
      end
    end
    if (flush) begin
      if (cnt_n != '0) begin
        a_fl   = 1'b1;
        fl_src = cnt_n;
      end
      state_n = RUN_IDLE;
      last_n  = '0;
      cnt_n   = '0;
    end
  end

  // Output: order the words into the two queue push slots. A flush count can
  // only be pending when the sample itself pushed nothing, so two slots suffice.
  always_comb begin
    cword_run = DW'(make_count_word(MAX_DW'(cnt_src), ew, repeat_mode));
    cword_fl  = DW'(make_count_word(MAX_DW'(fl_src), ew, repeat_mode));
    vword     = a_byp ? m_byp : m_val;
    push0     = 1'b0;
    push1     = 1'b0;
    w0        = '0;
    w1        = '0;
    if (a_cnt) begin
      push0 = 1'b1;
      w0    = cword_run;
    end
    if (a_val || a_byp) begin
      if (!push0) begin
        push0 = 1'b1;
        w0    = vword;
      end else begin
        push1 = 1'b1;
        w1    = vword;
      end
    end
    if (a_fl) begin
      if (!push0) begin
        push0 = 1'b1;
        w0    = cword_fl;
      end else begin
        push1 = 1'b1;
        w1    = cword_fl;
      end
    end
  end

  rle_outq #(
    .DW     (DW),
    .QDEPTH (QDEPTH)
  ) u_outq (
    .clock    (clock),
    .reset    (reset),
    .push0    (push0),
    .wdata0   (w0),
    .push1    (push1),
    .wdata1   (w1),
    .stall    (test_stall),
    .rdata    (dataOut),
    .rvalid   (validOut),
    .empty    (q_empty),
    .overflow (overflow)
  );

  // flush_done fires after the first post-flush cycle with an empty queue and
  // no push; a new flush in that cycle re-arms it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else if (flush_pending && q_empty && !push0) begin
      flush_done    <= 1'b1;
      flush_pending <= flush;
    end else begin
      flush_done    <= 1'b0;
      flush_pending <= flush_pending || flush;
    end
  end

endmodule

// File: tb/tb_rle_encoder_param.sv
// Directed bench for rle_encoder_param (DW=32, QDEPTH=4). Stimulus pushes the
// hand-computed words into exp_q; the monitor pops and compares each word the
// DUT presents on validOut.
module tb_rle_encoder_param;
  localparam int DW     = 32;
  localparam int QDEPTH = 4;
  localparam int MODE_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [MODE_W-1:0] mode;
  logic              repeat_mode;
  logic [DW-1:0]     data_mask;
  logic              flush;
  logic [DW-1:0]     dataIn;
  logic              validIn;
  logic              test_stall;
  logic [DW-1:0]     dataOut;
  logic              validOut;
  logic              flush_done;
  logic              overflow;

  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  string         cur_test = "reset";

  // model state for the long alternating-run test
  logic          m_idle;
  logic [DW-1:0] m_last;
  int            m_cnt;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  rle_encoder_param #(
    .DW     (DW),
    .QDEPTH (QDEPTH),
    .MODE_W (MODE_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .repeat_mode (repeat_mode),
    .data_mask   (data_mask),
    .flush       (flush),
    .dataIn      (dataIn),
    .validIn     (validIn),
    .test_stall  (test_stall),
    .dataOut     (dataOut),
    .validOut    (validOut),
    .flush_done  (flush_done),
    .overflow    (overflow)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", cur_test, name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset && validOut) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s/unexpected_word: got 0x%08h expected no word", cur_test, dataOut);
      end else begin
        check("word", dataOut, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] d);
    dataIn  = d;
    validIn = 1'b1;
    tick();
    validIn = 1'b0;
  endtask

  task automatic expect_word(input logic [DW-1:0] w);
    exp_q.push_back(w);
  endtask

  // Waits for flush_done (bounded), returns negedges waited, checks it is one cycle wide.
  task automatic wait_done(input string name, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clock);
      if (flush_done) begin
        got = 1'b1;
        lat = i;
      end
    end
    check({name, "_arrived"}, {31'd0, got}, 32'd1);
    check({name, "_queue_drained"}, exp_q.size(), 32'd0);
    @(negedge clock);
    check({name, "_single_pulse"}, {31'd0, flush_done}, 32'd0);
    tick();
  endtask

  task automatic close_run(input string name);
    int lat;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(name, lat);
    tick();
  endtask

  task automatic configure(input logic [MODE_W-1:0] md, input logic [DW-1:0] mask, input logic rep);
    mode        = md;
    data_mask   = mask;
    repeat_mode = rep;
  endtask

  // ---------------- reference model (alternating test) ----------------
  task automatic model_sample(input logic [DW-1:0] m);
    if (m_idle) begin
      expect_word(m);
      m_idle = 1'b0;
      m_last = m;
      m_cnt  = 0;
    end else if (m == m_last) begin
      m_cnt++;
      if (m_cnt == 32'h7FFF_FFFF) begin
        expect_word(32'hFFFF_FFFF);
        m_cnt = 0;
      end
    end else begin
      if (m_cnt > 0) expect_word(32'h8000_0000 | 32'(m_cnt));
      expect_word(m);
      m_last = m;
      m_cnt  = 0;
    end
  endtask

  task automatic model_flush();
    if (!m_idle && m_cnt > 0) expect_word(32'h8000_0000 | 32'(m_cnt));
    m_idle = 1'b1;
    m_cnt  = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    int sent;
    int k;
    logic [DW-1:0] d;

    reset      = 1'b1;
    enable     = 1'b1;
    flush      = 1'b0;
    validIn    = 1'b0;
    dataIn     = '0;
    test_stall = 1'b0;
    configure(2'd0, 32'h7F, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("validOut_in_reset", {31'd0, validOut}, 32'd0);
    check("dataOut_in_reset", dataOut, 32'd0);
    check("flush_done_in_reset", {31'd0, flush_done}, 32'd0);
    check("overflow_in_reset", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // idle flush with empty queue: pulse one cycle after the flush
    cur_test = "idle_flush";
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done("idle", lat);
    check("latency", lat, 32'd2);

    // 0x05, 0x06 x5, 0x07
    cur_test = "basic";
    expect_word(32'h05); expect_word(32'h06); expect_word(32'h84); expect_word(32'h07);
    sample(32'h05);
    repeat (5) sample(32'h06);
    sample(32'h07);
    close_run("basic");

    cur_test = "basic_repeat";
    configure(2'd0, 32'h7F, 1'b1);
    expect_word(32'h05); expect_word(32'h06); expect_word(32'h85); expect_word(32'h07);
    sample(32'h05);
    repeat (5) sample(32'h06);
    sample(32'h07);
    close_run("basic_repeat");

    // one value word plus 300 repeats: 127 + 127 + 46
    cur_test = "saturate";
    configure(2'd0, 32'h7F, 1'b0);
    expect_word(32'h11); expect_word(32'hFF); expect_word(32'hFF);
    expect_word(32'hAE); expect_word(32'h12);
    repeat (301) sample(32'h11);
    sample(32'h12);
    close_run("saturate");

    // repeat_mode: split after 126 repeats reports 127; one more repeat then flush reports 2
    cur_test = "saturate_repeat";
    configure(2'd0, 32'h7F, 1'b1);
    expect_word(32'h33); expect_word(32'hFF); expect_word(32'h82);
    repeat (128) sample(32'h33);
    close_run("saturate_repeat");

    // explicit flush closes the run; the next equal sample starts a new run
    cur_test = "flush_run";
    configure(2'd0, 32'h7F, 1'b0);
    expect_word(32'h22); expect_word(32'h89);
    repeat (10) sample(32'h22);
    close_run("flush_run");
    expect_word(32'h22);
    sample(32'h22);
    close_run("flush_run_after");

    // 16-bit words: flag bit 15 cleared on values, bits above 15 dropped
    cur_test = "mode1";
    configure(2'd1, 32'hFFFF_FFFF, 1'b0);
    expect_word(32'h2BCD); expect_word(32'h8002);
    repeat (3) sample(32'h1234_ABCD);
    close_run("mode1");

    // bypass discards the pending count and passes the flag bit through
    cur_test = "enable_change";
    configure(2'd0, 32'hFF, 1'b0);
    expect_word(32'h44); expect_word(32'hC4); expect_word(32'h44);
    repeat (3) sample(32'h44);
    enable = 1'b0;
    sample(32'hC4);
    enable = 1'b1;
    sample(32'h44);
    close_run("enable_change");

    // runs of 2,1,2,1... every cycle, 32-bit words, bit 31 forced low
    cur_test = "alternating";
    configure(2'd3, 32'hFFFF_FFFF, 1'b0);
    m_idle = 1'b1;
    m_last = '0;
    m_cnt  = 0;
    sent = 0;
    k    = 0;
    while (sent < 1000) begin
      for (int j = 0; j < ((k % 2 == 0) ? 2 : 1) && sent < 1000; j++) begin
        d = 32'h8000_0000 | 32'(k * 3 + 1);
        model_sample(d & 32'h7FFF_FFFF);
        sample(d);
        sent++;
      end
      k++;
    end
    model_flush();
    close_run("alternating");
    check("no_overflow", {31'd0, overflow}, 32'd0);

    // stalled queue: four words fit, the fifth is dropped
    cur_test = "overflow";
    configure(2'd0, 32'hFF, 1'b0);
    enable     = 1'b0;
    test_stall = 1'b1;
    expect_word(32'h81); expect_word(32'h02); expect_word(32'h03); expect_word(32'h04);
    sample(32'h81); sample(32'h02); sample(32'h03); sample(32'h04);
    check("clear_at_depth", {31'd0, overflow}, 32'd0);
    sample(32'h05);
    check("set_on_fifth", {31'd0, overflow}, 32'd1);
    test_stall = 1'b0;
    repeat (8) tick();
    check("sticky", {31'd0, overflow}, 32'd1);
    check("drained", exp_q.size(), 32'd0);

    // async reset with words queued: nothing emerges afterwards
    cur_test = "reset_mid_run";
    enable     = 1'b1;
    test_stall = 1'b1;
    sample(32'h55); sample(32'h55); sample(32'h66);
    #3 reset = 1'b1;
    #1;
    check("validOut_async", {31'd0, validOut}, 32'd0);
    check("overflow_async", {31'd0, overflow}, 32'd0);
    tick();
    reset      = 1'b0;
    test_stall = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (validOut) seen++;
    end
    check("queue_empty_after_reset", seen, 32'd0);
    tick();
    expect_word(32'h55);
    sample(32'h55);
    close_run("after_reset");

    // final drain (bounded)
    cur_test = "final";
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("all_words_seen", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
